// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry into the result MSB, recovered from the sum bit and its two addend bits.
    function automatic logic msb_carry_in(input logic s, input logic a, input logic b);
        return s ^ a ^ b;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between the ALU front end and the sequencer.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, overflow
    );

endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// Shared 4-bit ripple-carry adder datapath.
module adder4
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c_o
);

    logic [NIBBLE_W:0] carry;

    // Ripple the carry bit by bit through the nibble.
    always_comb begin
        carry    = '0;
        s_o      = '0;
        carry[0] = c_i;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Add/subtract sequencer: time-shares one adder4, one nibble per clock, LSB first.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic                      clk,
    input logic                      reset,
    nibble_serial_adder_ctrl_if.slave bus
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // b already inverted for subtraction
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, add_s;
    logic                add_c;

    // Select the current nibble of each operand for the shared adder.
    always_comb begin
        a_nib = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[idx_q * NIBBLE_W +: NIBBLE_W];
    end

    adder4 u_adder4 (
        .a_i (a_nib),
        .b_i (b_nib),
        .c_i (carry_q),
        .s_o (add_s),
        .c_o (add_c)
    );

    // Next-state, operand capture, nibble write-back and final flag computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q * NIBBLE_W +: NIBBLE_W] = add_s;
                carry_d = add_c;
                if (idx_q == LAST_IDX) begin
                    // The last nibble holds the MSB, so its bits give the carry into the MSB.
                    c_out_d = add_c;
                    ovf_d   = msb_carry_in(add_s[NIBBLE_W-1], a_nib[NIBBLE_W-1],
                                           b_nib[NIBBLE_W-1]) ^ add_c;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_done = 1'b0;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected result every time the DUT signals done.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_done <= 1'b0;
        end else begin
            if (bus.done) begin
                check("done_single_cycle", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(bus.sum), 32'(e.sum));
                    check("c_out", 32'(bus.c_out), 32'(e.c_out));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                end
            end
            prev_done <= bus.done;
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum   = es;
        e.c_out = ec;
        e.ovf   = eo;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: got busy/done stuck expected idle within 20 cycles");
        end
    endtask

    // Waits up to 12 cycles for done after an accepting edge; checks the 4-edge latency.
    task automatic wait_done(input string tag, input logic [WIDTH-1:0] es);
        bit seen = 1'b0;
        int lat  = 999;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = k - 1;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        if (seen) begin
            @(negedge clk);
            check({tag, "_sum_hold"}, 32'(bus.sum), 32'(es));
            check({tag, "_done_low"}, 32'(bus.done), 32'd0);
        end
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [WIDTH-1:0] es, input logic ec,
                         input logic eo);
        wait_idle();
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        push_exp(es, ec, eo);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.sub   = ~sub;
        wait_done(tag, es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_c_out", 32'(bus.c_out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_equal", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0);

        // start held high with operands toggling during RUN
        wait_idle();
        bus.a     = 16'h0F0F;
        bus.b     = 16'h00F1;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        push_exp(16'h1000, 1'b0, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("held_busy", 32'(bus.busy), (c <= 4) ? 32'd1 : 32'd0);
            check("held_done", 32'(bus.done), (c == 5) ? 32'd1 : 32'd0);
            if (c <= 5) begin
                bus.a   = 16'($urandom);
                bus.b   = 16'($urandom);
                bus.sub = 1'($urandom);
            end else begin
                bus.a   = 16'h1111;
                bus.b   = 16'h2222;
                bus.sub = 1'b1;
                push_exp(16'hEEEF, 1'b0, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        bus.sub   = 1'b0;
        check("reaccept_at_6", 32'(bus.busy), 32'd1);
        wait_done("held_second", 16'hEEEF);

        // leave c_out/overflow set so the mid-run reset has something to clear
        do_op("add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // reset at the second RUN edge
        wait_idle();
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_c_out", 32'(bus.c_out), 32'd0);
        check("midrst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        do_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
